// File: rtl/minmax_tracker_if.sv
// Bundles the sample input, shared comparator and frame-result handshakes of minmax_tracker.
// The slave modport is the tracker; master is the surrounding logic (source, comparator, sink).
`timescale 1ns/1ps
interface minmax_tracker_if #(
   parameter int WIDTH = 8
);
   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] IN_DATA;
   logic             IN_LAST;
   logic [WIDTH-1:0] CMP_A;
   logic [WIDTH-1:0] CMP_B;
   logic [1:0]       CMP_RES;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] OUT_MAX;
   logic [WIDTH-1:0] OUT_MIN;
   logic [7:0]       OUT_MAX_IDX;
   logic [7:0]       OUT_CNT;
   logic             ERR;

   modport slave (
      input  IN_VALID, IN_DATA, IN_LAST, CMP_RES, OUT_READY,
      output IN_READY, CMP_A, CMP_B, OUT_VALID, OUT_MAX, OUT_MIN, OUT_MAX_IDX, OUT_CNT, ERR
   );

   modport master (
      output IN_VALID, IN_DATA, IN_LAST, CMP_RES, OUT_READY,
      input  IN_READY, CMP_A, CMP_B, OUT_VALID, OUT_MAX, OUT_MIN, OUT_MAX_IDX, OUT_CNT, ERR
   );
endinterface

// File: rtl/minmax_tracker.sv
// Frame-based running max/min tracker that time-shares one external magnitude comparator
// between the max and min updates, emitting one result word per frame.
`timescale 1ns/1ps
module minmax_tracker #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 8
) (
   input logic CLK,
   input logic RST,
   minmax_tracker_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_CMPMAX, S_CMPMIN, S_OUT} state_t;

   localparam logic [7:0] FRAME_LEN_C = 8'(FRAME_LEN);
   localparam logic [1:0] RES_GT      = 2'd1;
   localparam logic [1:0] RES_LT      = 2'd2;
   localparam logic [1:0] RES_BAD     = 2'd3;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic [WIDTH-1:0] min_q, min_d;
   logic [WIDTH-1:0] sample_q, sample_d;
   logic [7:0]       idx_q, idx_d;
   logic [7:0]       max_idx_q, max_idx_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             last_q, last_d;
   logic             err_q, err_d;

   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] cmp_a, cmp_b;

   // IN_READY is held low while reset is asserted even though the state is already idle.
   assign in_ready  = (state_q == S_IDLE) && !RST;
   assign out_valid = (state_q == S_OUT);

   always_comb begin
      state_d   = state_q;
      max_d     = max_q;
      min_d     = min_q;
      sample_d  = sample_q;
      idx_d     = idx_q;
      max_idx_d = max_idx_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      err_d     = err_q;
      cmp_a     = '0;
      cmp_b     = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.IN_VALID && in_ready) begin
               sample_d = bus.IN_DATA;
               idx_d    = cnt_q;
               cnt_d    = cnt_q + 8'd1;
               last_d   = bus.IN_LAST || ((cnt_q + 8'd1) == FRAME_LEN_C);
               if (cnt_q == 8'd0) begin
                  // First sample seeds both extremes without touching the comparator.
                  max_d     = bus.IN_DATA;
                  min_d     = bus.IN_DATA;
                  max_idx_d = 8'd0;
                  state_d   = last_d ? S_OUT : S_IDLE;
               end else begin
                  state_d = S_CMPMAX;
               end
            end
         end
         S_CMPMAX: begin
            cmp_a = sample_q;
            cmp_b = max_q;
            if (bus.CMP_RES == RES_BAD) begin
               err_d = 1'b1;
            end else if (bus.CMP_RES == RES_GT) begin
               // Strictly greater only, so a tie keeps the earliest index.
               max_d     = sample_q;
               max_idx_d = idx_q;
            end
            state_d = S_CMPMIN;
         end
         S_CMPMIN: begin
            cmp_a = sample_q;
            cmp_b = min_q;
            if (bus.CMP_RES == RES_BAD) begin
               err_d = 1'b1;
            end else if (bus.CMP_RES == RES_LT) begin
               min_d = sample_q;
            end
            state_d = last_q ? S_OUT : S_IDLE;
         end
         S_OUT: begin
            if (bus.OUT_READY) begin
               cnt_d   = 8'd0;
               last_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         max_q     <= '0;
         min_q     <= '0;
         sample_q  <= '0;
         idx_q     <= 8'd0;
         max_idx_q <= 8'd0;
         cnt_q     <= 8'd0;
         last_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         max_q     <= max_d;
         min_q     <= min_d;
         sample_q  <= sample_d;
         idx_q     <= idx_d;
         max_idx_q <= max_idx_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         err_q     <= err_d;
      end
   end

   assign bus.IN_READY    = in_ready;
   assign bus.CMP_A       = cmp_a;
   assign bus.CMP_B       = cmp_b;
   assign bus.OUT_VALID   = out_valid;
   assign bus.OUT_MAX     = out_valid ? max_q : '0;
   assign bus.OUT_MIN     = out_valid ? min_q : '0;
   assign bus.OUT_MAX_IDX = out_valid ? max_idx_q : 8'd0;
   assign bus.OUT_CNT     = out_valid ? cnt_q : 8'd0;
   assign bus.ERR         = err_q;
endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker with a behavioural comparator that can be forced to the illegal code.
`timescale 1ns/1ps
module tb_minmax_tracker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic force_illegal = 1'b0;
   logic mon_en = 1'b0;
   int   mon_cmp = 0;
   int   mon_bad = 0;
   int   checks = 0;
   int   failures = 0;

   minmax_tracker_if #(.WIDTH(8)) bus ();

   minmax_tracker #(.WIDTH(8), .FRAME_LEN(8)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Comparator model: 0 equal, 1 A>B, 2 A<B, 3 when forced illegal.
   always_comb begin
      if (force_illegal)              bus.CMP_RES = 2'd3;
      else if (bus.CMP_A == bus.CMP_B) bus.CMP_RES = 2'd0;
      else if (bus.CMP_A > bus.CMP_B)  bus.CMP_RES = 2'd1;
      else                             bus.CMP_RES = 2'd2;
   end

   always @(negedge clk) begin
      if (mon_en && (bus.CMP_A != 8'd0 || bus.CMP_B != 8'd0)) begin
         mon_cmp <= mon_cmp + 1;
         if (bus.CMP_RES != 2'd0) mon_bad <= mon_bad + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic send_sample(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = d;
      bus.IN_LAST  = l;
      while (!bus.IN_READY && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.IN_READY) check("send_timeout", 0, 1);
      @(negedge clk);
      bus.IN_VALID = 1'b0;
      bus.IN_LAST  = 1'b0;
      $display("sample data=%0d last=%0d", d, l);
   endtask

   task automatic wait_out(input string tag, input logic [7:0] mx, input logic [7:0] mn,
                           input logic [7:0] mi, input logic [7:0] cn);
      int n;
      n = 0;
      while (!bus.OUT_VALID && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.OUT_VALID) begin
         check({tag, "_timeout"}, 0, 1);
         return;
      end
      $display("result %s max=%0d min=%0d idx=%0d cnt=%0d", tag, bus.OUT_MAX, bus.OUT_MIN,
               bus.OUT_MAX_IDX, bus.OUT_CNT);
      check({tag, "_max"}, bus.OUT_MAX, mx);
      check({tag, "_min"}, bus.OUT_MIN, mn);
      check({tag, "_idx"}, bus.OUT_MAX_IDX, mi);
      check({tag, "_cnt"}, bus.OUT_CNT, cn);
      bus.OUT_READY = 1'b1;
      @(negedge clk);
      bus.OUT_READY = 1'b0;
   endtask

   initial begin
      int   k;
      logic [7:0] td [3];
      logic exp_rdy [8];
      int   exp_a [8];
      int   exp_b [8];
      logic exp_ov [8];
      logic [7:0] full [8];

      bus.IN_VALID  = 1'b0;
      bus.IN_DATA   = 8'd0;
      bus.IN_LAST   = 1'b0;
      bus.OUT_READY = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", bus.IN_READY, 0);
      check("rst_out_valid", bus.OUT_VALID, 0);
      check("rst_out_max", bus.OUT_MAX, 0);
      check("rst_err", bus.ERR, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", bus.IN_READY, 1);

      // Reset mid-frame during S_CMPMAX
      send_sample(8'd10, 1'b0);
      send_sample(8'd200, 1'b0);
      check("midrst_cmp_a_before", bus.CMP_A, 200);
      rst = 1'b1;
      #1;
      check("midrst_cmp_a", bus.CMP_A, 0);
      check("midrst_cmp_b", bus.CMP_B, 0);
      check("midrst_out_valid", bus.OUT_VALID, 0);
      check("midrst_out_cnt", bus.OUT_CNT, 0);
      check("midrst_err", bus.ERR, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_sample(8'd5, 1'b1);
      wait_out("single", 8'd5, 8'd5, 8'd0, 8'd1);

      // Full frame ending on FRAME_LEN
      full = '{8'd0, 8'd10, 8'd20, 8'd5, 8'd255, 8'd3, 8'd255, 8'd7};
      for (int i = 0; i < 8; i++) send_sample(full[i], 1'b0);
      check("full_ov_cmpmax", bus.OUT_VALID, 0);
      @(negedge clk);
      check("full_ov_cmpmin", bus.OUT_VALID, 0);
      @(negedge clk);
      check("full_ov_rise", bus.OUT_VALID, 1);
      wait_out("full", 8'd255, 8'd0, 8'd4, 8'd8);

      // Early IN_LAST, all samples equal
      mon_en = 1'b1;
      send_sample(8'd20, 1'b0);
      send_sample(8'd20, 1'b0);
      send_sample(8'd20, 1'b1);
      wait_out("equal", 8'd20, 8'd20, 8'd0, 8'd3);
      mon_en = 1'b0;
      check("equal_cmp_cycles", 32'(mon_cmp), 4);
      check("equal_res_nonzero", 32'(mon_bad), 0);

      // Output back-pressure with a pending sample
      send_sample(8'd40, 1'b0);
      send_sample(8'd60, 1'b1);
      while (!bus.OUT_VALID) @(negedge clk);
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = 8'd77;
      bus.IN_LAST  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", bus.IN_READY, 0);
         check("bp_out_max", bus.OUT_MAX, 60);
         check("bp_out_cnt", bus.OUT_CNT, 2);
         @(negedge clk);
      end
      check("bp_out_min", bus.OUT_MIN, 40);
      check("bp_out_idx", bus.OUT_MAX_IDX, 1);
      bus.OUT_READY = 1'b1;
      @(negedge clk);
      bus.OUT_READY = 1'b0;
      check("bp_ready_after_accept", bus.IN_READY, 1);
      @(negedge clk);
      bus.IN_VALID = 1'b0;
      bus.IN_LAST  = 1'b0;
      wait_out("pending", 8'd77, 8'd77, 8'd0, 8'd1);

      // Cycle-accurate 3-sample frame
      td      = '{8'd3, 8'd9, 8'd4};
      exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_a   = '{0, 0, 9, 9, 0, 4, 4, 0};
      exp_b   = '{0, 0, 3, 3, 0, 9, 3, 0};
      exp_ov  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      k = 0;
      for (int c = 0; c < 8; c++) begin
         $display("cycle %0d in_ready=%0d cmp_a=%0d cmp_b=%0d out_valid=%0d", c, bus.IN_READY,
                  bus.CMP_A, bus.CMP_B, bus.OUT_VALID);
         check($sformatf("tm_in_ready_%0d", c), bus.IN_READY, exp_rdy[c]);
         check($sformatf("tm_cmp_a_%0d", c), bus.CMP_A, exp_a[c]);
         check($sformatf("tm_cmp_b_%0d", c), bus.CMP_B, exp_b[c]);
         check($sformatf("tm_out_valid_%0d", c), bus.OUT_VALID, exp_ov[c]);
         if (bus.IN_READY && k < 3) begin
            bus.IN_VALID = 1'b1;
            bus.IN_DATA  = td[k];
            bus.IN_LAST  = (k == 2);
            k++;
         end else begin
            bus.IN_VALID = 1'b0;
            bus.IN_LAST  = 1'b0;
         end
         @(negedge clk);
      end
      bus.IN_VALID = 1'b0;
      wait_out("timing", 8'd9, 8'd3, 8'd1, 8'd3);

      // Illegal comparator code during one S_CMPMAX
      send_sample(8'd10, 1'b0);
      send_sample(8'd50, 1'b1);
      force_illegal = 1'b1;
      @(negedge clk);
      force_illegal = 1'b0;
      check("illegal_err", bus.ERR, 1);
      wait_out("illegal", 8'd10, 8'd10, 8'd0, 8'd2);
      send_sample(8'd8, 1'b0);
      send_sample(8'd3, 1'b0);
      send_sample(8'd9, 1'b1);
      wait_out("after_err", 8'd9, 8'd3, 8'd2, 8'd3);
      check("err_sticky", bus.ERR, 1);

      // Only reset clears ERR
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("err_cleared", bus.ERR, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
